// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_stage_pkg;

    // Fetch FSM encoding (2-bit state register)
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HOLD  = 2'd1,
        FS_DROP  = 2'd2
    } fs_state_e;

    // Default bubble instruction: sll $0,$0,0
    localparam logic [31:0] FS_NOP_INS = 32'h0000_0000;

    // Word-align an address by clearing the byte-offset bits
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INS = FS_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] ins_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] ins_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Flush beats load; with neither asserted the register holds (decode stall)
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_q   <= NOP_INS;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            ins_q   <= NOP_INS;
            valid_q <= 1'b0;
        end else if (load_i) begin
            ins_q   <= ins_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign ins_o   = ins_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, memory req/ack FSM and stall hold buffer
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = FS_NOP_INS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] Ins,
    output logic [31:0] PcPlus4,
    output logic        InsValid
);

    fs_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_ins_q, hold_ins_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic        ifid_load;
    logic        ifid_flush;
    logic [31:0] ifid_ins;
    logic [31:0] ifid_pc4;

    logic        xfer;
    logic [31:0] redir_pc;
    logic [31:0] req_pc4;

    // Request depends only on state (and reset), never on IAck or Stall
    assign IReq     = !RST && (state_q != FS_HOLD);
    assign IAddr    = req_addr_q;
    assign xfer     = IReq && IAck;
    assign redir_pc = word_align(RedirectPC);
    assign req_pc4  = req_addr_q + 32'd4;

    // Next-state, PC and IF/ID control; Redirect > Stall > load/bubble
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_ins_d = hold_ins_q;
        hold_pc4_d = hold_pc4_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_ins   = IData;
        ifid_pc4   = req_pc4;

        case (state_q)
            FS_FETCH: begin
                if (xfer) begin
                    if (Redirect) begin
                        pc_d       = redir_pc;
                        req_addr_d = redir_pc;
                        ifid_flush = 1'b1;
                    end else if (Stall) begin
                        // Decode can't take it: park the word, resume after release
                        hold_ins_d = IData;
                        hold_pc4_d = req_pc4;
                        pc_d       = req_pc4;
                        state_d    = FS_HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        pc_d       = req_pc4;
                        req_addr_d = req_pc4;
                    end
                end else begin
                    if (Redirect) begin
                        // Request already on the bus must complete; drop its data
                        pc_d       = redir_pc;
                        state_d    = FS_DROP;
                        ifid_flush = 1'b1;
                    end else if (!Stall) begin
                        ifid_flush = 1'b1;
                    end
                end
            end

            FS_HOLD: begin
                if (Redirect) begin
                    pc_d       = redir_pc;
                    req_addr_d = redir_pc;
                    hold_ins_d = 32'h0;
                    hold_pc4_d = 32'h0;
                    ifid_flush = 1'b1;
                    state_d    = FS_FETCH;
                end else if (!Stall) begin
                    ifid_load  = 1'b1;
                    ifid_ins   = hold_ins_q;
                    ifid_pc4   = hold_pc4_q;
                    req_addr_d = pc_q;
                    state_d    = FS_FETCH;
                end
            end

            FS_DROP: begin
                if (Redirect) begin
                    pc_d       = redir_pc;
                    ifid_flush = 1'b1;
                end else if (!Stall) begin
                    ifid_flush = 1'b1;
                end
                if (xfer) begin
                    req_addr_d = Redirect ? redir_pc : pc_q;
                    state_d    = FS_FETCH;
                end
            end

            default: begin
                state_d    = FS_FETCH;
                req_addr_d = pc_q;
            end
        endcase
    end

    // State, PC and hold buffer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FS_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_ins_q <= 32'h0;
            hold_pc4_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_ins_q <= hold_ins_d;
            hold_pc4_q <= hold_pc4_d;
        end
    end

    if_id_reg #(
        .NOP_INS (NOP_INS)
    ) u_if_id_reg (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .ins_i   (ifid_ins),
        .pc4_i   (ifid_pc4),
        .ins_o   (Ins),
        .pc4_o   (PcPlus4),
        .valid_o (InsValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] IData;
    logic [31:0] Ins;
    logic [31:0] PcPlus4;
    logic        InsValid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IReq       (IReq),
        .IAddr      (IAddr),
        .IAck       (IAck),
        .IData      (IData),
        .Ins        (Ins),
        .PcPlus4    (PcPlus4),
        .InsValid   (InsValid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign IData = w(IAddr);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; IAck = 1'b0;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; IAck = 1'b1;
        step();
        step();
        n_checks++;
        if ({IReq, InsValid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctrl: IReq,InsValid=%b required 00", {IReq, InsValid});
        end
        n_checks++;
        if ({Ins, PcPlus4} !== 64'h0) begin
            n_fail++; $display("FAIL reset_ifid: Ins=%h PcPlus4=%h required 0/0", Ins, PcPlus4);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if ({IReq, IAddr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL reset_first_req: IReq=%b IAddr=%h required 1/00000000", IReq, IAddr);
        end
    endtask

    task automatic test_zero_wait();
        apply_reset();
        IAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({IReq, IAddr} !== {1'b1, 32'(i * 4)}) begin
                n_fail++; $display("FAIL zw_addr[%0d]: IReq=%b IAddr=%h required 1/%h", i, IReq, IAddr, 32'(i * 4));
            end
            step();
            n_checks++;
            if ({InsValid, Ins, PcPlus4} !== {1'b1, w(32'(i * 4)), 32'(i * 4 + 4)}) begin
                n_fail++; $display("FAIL zw_ifid[%0d]: v=%b Ins=%h Pc4=%h required 1/%h/%h",
                                   i, InsValid, Ins, PcPlus4, w(32'(i * 4)), 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        IAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) IAck = 1'b1;
            n_checks++;
            if ({IReq, IAddr} !== {1'b1, 32'h0}) begin
                n_fail++; $display("FAIL ws_addr[%0d]: IReq=%b IAddr=%h required 1/00000000", i, IReq, IAddr);
            end
            if (i > 0) begin
                n_checks++;
                if (InsValid !== 1'b0) begin
                    n_fail++; $display("FAIL ws_bubble[%0d]: InsValid=%b required 0", i, InsValid);
                end
            end
            step();
        end
        IAck = 1'b0;
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IAddr} !== {1'b1, w(32'h0), 32'h4, 32'h4}) begin
            n_fail++; $display("FAIL ws_result: v=%b Ins=%h Pc4=%h IAddr=%h required 1/%h/4/4",
                               InsValid, Ins, PcPlus4, IAddr, w(32'h0));
        end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        IAck = 1'b1;
        step();
        step();
        Stall = 1'b1;
        n_checks++;
        if (IAddr !== 32'h8) begin
            n_fail++; $display("FAIL st_addr8: IAddr=%h required 00000008", IAddr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) Stall = 1'b0;
            n_checks++;
            if ({IReq, InsValid, Ins, PcPlus4} !== {1'b0, 1'b1, w(32'h4), 32'h8}) begin
                n_fail++; $display("FAIL st_hold[%0d]: IReq=%b v=%b Ins=%h Pc4=%h required 0/1/%h/8",
                                   i, IReq, InsValid, Ins, PcPlus4, w(32'h4));
            end
        end
        step();
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IReq, IAddr} !== {1'b1, w(32'h8), 32'hC, 1'b1, 32'hC}) begin
            n_fail++; $display("FAIL st_release: v=%b Ins=%h Pc4=%h IReq=%b IAddr=%h required 1/%h/c/1/c",
                               InsValid, Ins, PcPlus4, IReq, IAddr, w(32'h8));
        end
        step();
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IAddr} !== {1'b1, w(32'hC), 32'h10, 32'h10}) begin
            n_fail++; $display("FAIL st_next: v=%b Ins=%h Pc4=%h IAddr=%h required 1/%h/10/10",
                               InsValid, Ins, PcPlus4, IAddr, w(32'hC));
        end
    endtask

    task automatic test_redirect_pending();
        apply_reset();
        IAck = 1'b1;
        for (int i = 0; i < 4; i++) step();
        IAck = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        step();
        Redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({IReq, IAddr, InsValid} !== {1'b1, 32'h10, 1'b0}) begin
                n_fail++; $display("FAIL rd_pending[%0d]: IReq=%b IAddr=%h v=%b required 1/10/0",
                                   i, IReq, IAddr, InsValid);
            end
            if (i == 1) IAck = 1'b1;
            step();
        end
        n_checks++;
        if ({IAddr, InsValid} !== {32'h100, 1'b0}) begin
            n_fail++; $display("FAIL rd_target: IAddr=%h v=%b required 100/0", IAddr, InsValid);
        end
        step();
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IAddr} !== {1'b1, w(32'h100), 32'h104, 32'h104}) begin
            n_fail++; $display("FAIL rd_fetch: v=%b Ins=%h Pc4=%h IAddr=%h required 1/%h/104/104",
                               InsValid, Ins, PcPlus4, IAddr, w(32'h100));
        end
    endtask

    task automatic test_redirect_in_hold();
        apply_reset();
        IAck = 1'b1;
        step();
        Stall = 1'b1;
        step();
        n_checks++;
        if ({IReq, InsValid, Ins} !== {1'b0, 1'b1, w(32'h0)}) begin
            n_fail++; $display("FAIL rh_hold: IReq=%b v=%b Ins=%h required 0/1/%h", IReq, InsValid, Ins, w(32'h0));
        end
        Redirect = 1'b1; RedirectPC = 32'h0000_0043;
        step();
        Redirect = 1'b0; Stall = 1'b0;
        n_checks++;
        if ({InsValid, Ins, IReq, IAddr} !== {1'b0, 32'h0, 1'b1, 32'h40}) begin
            n_fail++; $display("FAIL rh_flush: v=%b Ins=%h IReq=%b IAddr=%h required 0/0/1/40",
                               InsValid, Ins, IReq, IAddr);
        end
        step();
        n_checks++;
        if ({InsValid, Ins, PcPlus4} !== {1'b1, w(32'h40), 32'h44}) begin
            n_fail++; $display("FAIL rh_fetch: v=%b Ins=%h Pc4=%h required 1/%h/44", InsValid, Ins, PcPlus4, w(32'h40));
        end
    endtask

    task automatic test_reset_drop_and_wrap();
        apply_reset();
        IAck = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        Redirect = 1'b0;
        RST = 1'b1; IAck = 1'b1;
        #1;
        n_checks++;
        if (IReq !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop_ireq: IReq=%b required 0", IReq);
        end
        step();
        RST = 1'b0;
        #1;
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IReq, IAddr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rst_drop_state: v=%b Ins=%h Pc4=%h IReq=%b IAddr=%h required 0/0/0/1/0",
                               InsValid, Ins, PcPlus4, IReq, IAddr);
        end
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        n_checks++;
        if ({IAddr, InsValid} !== {32'hFFFF_FFFC, 1'b0}) begin
            n_fail++; $display("FAIL wrap_target: IAddr=%h v=%b required fffffffc/0", IAddr, InsValid);
        end
        step();
        n_checks++;
        if ({InsValid, Ins, PcPlus4, IAddr} !== {1'b1, w(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL wrap_pc4: v=%b Ins=%h Pc4=%h IAddr=%h required 1/%h/0/0",
                               InsValid, Ins, PcPlus4, IAddr, w(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_in_hold();
        test_reset_drop_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline, sitting directly upstream of the decode/register-file stage (JOIN), which it feeds through the IF/ID register (`Ins`, `PcPlus4`, `InsValid`). Owns the program counter. Issues word fetches to instruction memory over a req/ack handshake and absorbs decode stalls with a one-entry hold buffer. Handles branch/jump redirects, including a redirect that arrives while a fetch is outstanding.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `NOP_INS`, 32'h0000_0000: value driven on `Ins` when invalid (sll $0,$0,0).

Ports:
- `CLK` in 1: the single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Stall` in 1: decode hazard; IF/ID must hold its contents.
- `Redirect` in 1: branch/jump taken; flush and refetch.
- `RedirectPC` in 32: target, sampled when `Redirect`=1.
- `IReq` out 1: instruction-memory request.
- `IAddr` out 32: word address of request; bits [1:0] always 0.
- `IAck` in 1: memory completes the request this cycle.
- `IData` in 32: instruction word, valid when `IReq`&`IAck`.
- `Ins` out 32: IF/ID instruction to decode.
- `PcPlus4` out 32: IF/ID address of `Ins` + 4.
- `InsValid` out 1: IF/ID holds a real instruction.

## Operation
- Registers: `pc` (next address to fetch), `req_addr` (address of the in-flight request), `hold_ins`/`hold_pc4` buffer, 2-bit state, and IF/ID (`Ins`, `PcPlus4`, `InsValid`).
- Transfer = `IReq`&`IAck` in the same cycle. Once `IReq` rises, `IAddr` is stable until the transfer. `IAck` may arrive in the first request cycle (zero wait) or any later cycle.
- State FETCH: `IReq`=1, `IAddr`=`req_addr`.
  - Transfer & `Redirect`: discard data; `pc`, `req_addr` ← `RedirectPC`; stay in FETCH.
  - Transfer & `Stall`: hold buffer ← {`IData`, `req_addr`+4}; `pc` += 4; go to HOLD.
  - Transfer, otherwise: IF/ID ← {`IData`, `req_addr`+4, 1}; `pc`, `req_addr` += 4.
  - No transfer & `Redirect`: `pc` ← `RedirectPC`; go to DROP; `req_addr` unchanged.
  - No transfer & !`Stall`: `InsValid` ← 0 (bubble).
- State HOLD: `IReq`=0.
  - `Redirect`: discard buffer; `req_addr` ← `RedirectPC`; go to FETCH.
  - !`Stall`: IF/ID ← {buffer, 1}; `req_addr` ← `pc`; go to FETCH.
- State DROP: `IReq`=1 at the old `IAddr`.
  - On transfer: discard data; `req_addr` ← `pc`; go to FETCH.
  - A further `Redirect` in DROP overwrites `pc`.
- IF/ID priority: `Redirect` > `Stall` > load/bubble.
  - `Redirect`: `InsValid` ← 0, `Ins` ← `NOP_INS`.
  - `Stall` alone: IF/ID unchanged.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. `RedirectPC`[1:0] is ignored and forced to 0.

## Timing
- During `RST`: `pc`=`req_addr`=`RESET_PC`, state FETCH, `IReq`=0, `Ins`=`NOP_INS`, `PcPlus4`=0, `InsValid`=0, buffer cleared. `RST` overrides all inputs, including mid-transfer; any in-flight memory response is not tracked.
- First cycle after reset: `IReq`=1, `IAddr`=`RESET_PC`.
- Latency: transfer in cycle N → `Ins`/`InsValid` visible in cycle N+1.
- Zero-wait memory: one instruction per cycle.
- Redirect in cycle N: `InsValid`=0 in N+1. From FETCH with a transfer (or from HOLD), `IAddr`=`RedirectPC` in N+1. From DROP, `IAddr`=`RedirectPC` in the cycle after the pending ack.
- Stall release from HOLD in cycle N: buffered instruction valid in N+1, new request issued in N+1.
- `IReq` combinational from state only; no combinational path from `IAck`/`Stall` to `IReq`.

## Structure
- Add to `common_param.vh`: state localparams `FS_FETCH`=2'd0, `FS_HOLD`=2'd1, `FS_DROP`=2'd2, and `NOP_INS`.
- One sub-module, `if_id_reg`: IF/ID register with load/hold/flush inputs and NOP reset. The top contains the PC, the FSM and the hold buffer.

## Test plan
- Reset, zero-wait memory returning `IAddr`-indexed words → `IAddr` 0,4,8,…; `Ins` follows one cycle later; `PcPlus4`=4,8,12; `InsValid`=1 continuously.
- `IAck` delayed 3 cycles → `IAddr` stable 4 cycles, 3 bubble cycles of `InsValid`=0, then the instruction appears.
- `Stall`=1 for 3 cycles at the transfer of address 0x8 → `Ins` keeps word@0x4, `IReq`=0. After release: word@0x8 then word@0xC, no loss or duplicates.
- `Redirect` to 0x100 while a transfer at 0x10 is pending with no ack → `IAddr` holds 0x10 until ack, data dropped, next `IAddr`=0x100, `InsValid`=0 during the gap.
- `Redirect` (0x40) and `Stall` together in HOLD → buffer discarded, `InsValid`=0, next `IAddr`=0x40.
- `RST` asserted mid-DROP, then PC wrap from 0xFFFF_FFFC → outputs return to reset values, `IAddr`=`RESET_PC`; the wrap case produces `PcPlus4`=0.
